// File: rtl/state_dump_unit.sv
// Halts the CPU and streams PC, registers and data memory over a valid/ready port.
// Define DUMP_CHECKSUM_EN to append a modulo-2^32 sum of all emitted words as a final beat.
module state_dump_unit #(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        halt_o,
  output logic        busy_o,
  output logic [31:0] dout_o,
  output logic [9:0]  dout_tag_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        done_o
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, S_PC, S_REG, S_MEM, S_CSUM, S_FIN} state_e;
`else
  typedef enum logic [2:0] {IDLE, S_PC, S_REG, S_MEM, S_FIN} state_e;
`endif

  localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);
  localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] dout_q, dout_d;
  logic [9:0]  tag_q, tag_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        load;
  logic        emit;
  logic [31:0] emit_data;
  logic [9:0]  emit_tag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Word presented by the current state; only captured when the output slot is free.
  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    emit_tag  = '0;
    case (state_q)
      S_PC: begin
        emit      = 1'b1;
        emit_data = pc_i;
        emit_tag  = {2'd0, 8'd0};
      end
      S_REG: begin
        emit      = 1'b1;
        emit_data = reg_data_i;
        emit_tag  = {2'd1, idx_q};
      end
      S_MEM: begin
        emit      = 1'b1;
        emit_data = mem_data_i;
        emit_tag  = {2'd2, idx_q};
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        emit      = 1'b1;
        emit_data = sum_q;
        emit_tag  = {2'd3, 8'd0};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    load = !valid_q || dout_ready_i;

    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = S_PC;
        idx_d   = '0;
        busy_d  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
    end else if (emit && load) begin
      dout_d  = emit_data;
      tag_d   = emit_tag;
      valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
      sum_d   = sum_q + emit_data;
`endif
      case (state_q)
        S_PC: begin
          state_d = S_REG;
          idx_d   = '0;
        end
        S_REG: begin
          if (idx_q == REG_LAST) begin
            state_d = S_MEM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        S_MEM: begin
          if (idx_q == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: begin
          state_d = S_FIN;
          idx_d   = '0;
        end
      endcase
    end else if (state_q == S_FIN && load) begin
      // Final beat has been accepted: release the core and pulse done.
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  assign reg_addr_o   = (state_q == S_REG) ? idx_q[4:0] : '0;
  assign mem_addr_o   = (state_q == S_MEM) ? {22'd0, idx_q, 2'b00} : '0;
  assign halt_o       = busy_q;
  assign busy_o       = busy_q;
  assign dout_o       = dout_q;
  assign dout_tag_o   = tag_q;
  assign dout_valid_o = valid_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: default and small configurations.
`timescale 1ns/1ps
module tb_state_dump_unit;
  localparam int NREG = 32;
  localparam int NMEM = 32;
  localparam int SREG = 2;
  localparam int SMEM = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  typedef logic [41:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        halt, busy, valid, done;
  logic        ready = 1'b0;
  logic [31:0] dout;
  logic [9:0]  tag;

  logic        s_start = 1'b0;
  logic        s_ready = 1'b0;
  logic [4:0]  s_reg_addr;
  logic [31:0] s_reg_data;
  logic [31:0] s_mem_addr;
  logic [31:0] s_mem_data;
  logic        s_halt, s_busy, s_valid, s_done;
  logic [31:0] s_dout;
  logic [9:0]  s_tag;

  logic [31:0] regs [32];
  logic [31:0] mems [256];

  assign reg_data   = regs[reg_addr];
  assign mem_data   = mems[mem_addr[9:2]];
  assign s_reg_data = regs[s_reg_addr];
  assign s_mem_data = mems[s_mem_addr[9:2]];

  always #5 clk = ~clk;

  state_dump_unit #(.MEM_WORDS(NMEM), .REG_COUNT(NREG)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
    .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .halt_o(halt), .busy_o(busy), .dout_o(dout), .dout_tag_o(tag),
    .dout_valid_o(valid), .dout_ready_i(ready), .done_o(done)
  );

  state_dump_unit #(.MEM_WORDS(SMEM), .REG_COUNT(SREG)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .pc_i(pc),
    .reg_addr_o(s_reg_addr), .reg_data_i(s_reg_data),
    .mem_addr_o(s_mem_addr), .mem_data_i(s_mem_data),
    .halt_o(s_halt), .busy_o(s_busy), .dout_o(s_dout), .dout_tag_o(s_tag),
    .dout_valid_o(s_valid), .dout_ready_i(s_ready), .done_o(s_done)
  );

  int tests = 0;
  int fails = 0;

  beat_t exp_q[$];
  beat_t got_q[$];

  int   stall_err, halt_err, done_cnt, done_cyc, last_acc_cyc, first_valid_cyc;
  logic timed_out, extra_done, post_active;

  // Reference stream: what an ideal dump of the current CPU state looks like.
  task automatic build_expected(input int nreg, input int nmem);
    logic [31:0] sum;
    exp_q.delete();
    sum = pc;
    exp_q.push_back({10'h000, pc});
    for (int i = 0; i < nreg; i++) begin
      exp_q.push_back({2'd1, 8'(i), regs[i]});
      sum += regs[i];
    end
    for (int i = 0; i < nmem; i++) begin
      exp_q.push_back({2'd2, 8'(i), mems[i]});
      sum += mems[i];
    end
    if (CSUM != 0) exp_q.push_back({10'h300, sum});
  endtask

  function automatic int stream_diffs(output int first_bad);
    int n;
    beat_t g;
    n = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : '1;
      if (g !== exp_q[i]) begin
        n++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return n;
  endfunction

  task automatic randomize_state();
    pc = $urandom;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 256; i++) mems[i] = $urandom;
  endtask

  // Drive one dump on the main DUT. mode 0: ready high, 1: 1,0,0,1 pattern, 2: random.
  task automatic collect(input int mode, input int restart_beat);
    int    cyc;
    logic  fin, have_hold, restarted;
    beat_t hold;
    got_q.delete();
    stall_err = 0; halt_err = 0; done_cnt = 0; done_cyc = -1;
    last_acc_cyc = -1; first_valid_cyc = -1; timed_out = 1'b0;
    fin = 1'b0; have_hold = 1'b0; restarted = 1'b0; hold = '0; cyc = 0;
    @(negedge clk); start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 3000) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        if (!halt || !busy) halt_err++;
        if (valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (have_hold && {tag, dout} !== hold) stall_err++;
          if (ready) begin
            got_q.push_back({tag, dout});
            have_hold = 1'b0;
            last_acc_cyc = cyc;
            if (got_q.size() == restart_beat) begin
              start = 1'b1;
              restarted = 1'b1;
            end
          end else begin
            hold = {tag, dout};
            have_hold = 1'b1;
          end
        end
      end
      @(negedge clk);
      if (restarted) begin
        start = 1'b0;
        restarted = 1'b0;
      end
      cyc++;
    end
    timed_out = !fin;
    #1;
    extra_done  = done;
    post_active = halt | busy | valid;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests++;
    if ({halt, busy, valid, done} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: halt/busy/valid/done=%b want 0000", {halt, busy, valid, done});
    end
    tests++;
    if (dout !== 32'd0 || tag !== 10'd0) begin
      fails++;
      $display("FAIL reset_data: dout=%h tag=%h want 0", dout, tag);
    end
    tests++;
    if (reg_addr !== 5'd0 || mem_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_addr: reg_addr=%h mem_addr=%h want 0", reg_addr, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int nd, fb;
    pc = 32'h40;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    for (int i = 0; i < 256; i++) mems[i] = 32'(100 + i);
    build_expected(NREG, NMEM);
    collect(0, -1);
    tests++;
    if (timed_out !== 1'b0) begin fails++; $display("FAIL basic_timeout: no done_o within budget"); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_count: beats=%0d want %0d", got_q.size(), exp_q.size());
    end
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0) begin
      fails++;
      $display("FAIL basic_stream: %0d bad beats, first at %0d", nd, fb);
    end
    tests++;
    if (got_q.size() < 1 || got_q[0] !== {10'h000, 32'h40}) begin
      fails++; $display("FAIL basic_pc: beat0 wrong, want tag 000 data 00000040");
    end
    tests++;
    if (got_q.size() < 7 || got_q[6] !== {10'h105, 32'd15}) begin
      fails++; $display("FAIL basic_r5: beat6 wrong, want tag 105 data 15");
    end
    tests++;
    if (got_q.size() < 65 || got_q[64] !== {10'h21F, 32'd131}) begin
      fails++; $display("FAIL basic_mem31: beat64 wrong, want tag 21f data 131");
    end
    tests++;
    if (first_valid_cyc != 1) begin
      fails++; $display("FAIL basic_latency: first valid cycle=%0d want 1", first_valid_cyc);
    end
    tests++;
    if (done_cyc != last_acc_cyc + 1 || done_cnt != 1) begin
      fails++;
      $display("FAIL basic_done: done at %0d (count %0d), want %0d (count 1)", done_cyc, done_cnt, last_acc_cyc + 1);
    end
    tests++;
    if (extra_done !== 1'b0 || post_active !== 1'b0) begin
      fails++;
      $display("FAIL basic_release: done=%b active=%b after pulse, want 0 0", extra_done, post_active);
    end
    tests++;
    if (halt_err != 0) begin
      fails++; $display("FAIL basic_halt: %0d cycles with halt/busy low mid-dump, want 0", halt_err);
    end
  endtask

  task automatic test_backpressure(input int mode);
    int nd, fb;
    randomize_state();
    build_expected(NREG, NMEM);
    collect(mode, -1);
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0 || got_q.size() != exp_q.size() || timed_out) begin
      fails++;
      $display("FAIL bp_stream(mode %0d): %0d bad beats first %0d, beats=%0d want %0d, timeout=%b",
               mode, nd, fb, got_q.size(), exp_q.size(), timed_out);
    end
    tests++;
    if (stall_err != 0) begin
      fails++; $display("FAIL bp_stable(mode %0d): %0d changes while stalled, want 0", mode, stall_err);
    end
    tests++;
    if (halt_err != 0 || done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
      fails++;
      $display("FAIL bp_done(mode %0d): halt_err=%0d done_cnt=%0d done_cyc=%0d want 0 1 %0d",
               mode, halt_err, done_cnt, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_restart_ignored();
    int nd, fb;
    randomize_state();
    build_expected(NREG, NMEM);
    collect(0, 10);
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0 || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL restart_ignored: %0d bad beats first %0d, beats=%0d want %0d", nd, fb, got_q.size(), exp_q.size());
    end
    tests++;
    if (post_active !== 1'b0) begin
      fails++; $display("FAIL restart_idle: still active=%b after done, want 0", post_active);
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, cyc, nd, fb;
    randomize_state();
    build_expected(NREG, NMEM);
    n = 0; cyc = 0;
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n < 20 && cyc < 200) begin
      #1;
      if (valid && ready) n++;
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (valid !== 1'b1 || halt !== 1'b1) begin
      fails++; $display("FAIL rst_pre: valid=%b halt=%b while stalled, want 1 1", valid, halt);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({valid, halt, busy, done} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_async: valid/halt/busy/done=%b without clock edge, want 0000", {valid, halt, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    collect(0, -1);
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0 || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rst_restart: %0d bad beats first %0d, beats=%0d want %0d", nd, fb, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_small_config();
    int cyc, nd, fb;
    logic fin;
    randomize_state();
    build_expected(SREG, SMEM);
    got_q.delete();
    fin = 1'b0; cyc = 0;
    @(negedge clk); s_start = 1'b1; s_ready = 1'b1;
    @(negedge clk); s_start = 1'b0;
    while (!fin && cyc < 100) begin
      #1;
      if (s_done) fin = 1'b1;
      else if (s_valid && s_ready) got_q.push_back({s_tag, s_dout});
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!fin || got_q.size() != 7 + CSUM) begin
      fails++; $display("FAIL small_count: beats=%0d done=%b want %0d 1", got_q.size(), fin, 7 + CSUM);
    end
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0) begin
      fails++; $display("FAIL small_stream: %0d bad beats, first at %0d", nd, fb);
    end
    tests++;
    if (got_q.size() < 7 || got_q[2][41:32] !== 10'h101 || got_q[6][41:32] !== 10'h203) begin
      fails++; $display("FAIL small_tags: beat2/beat6 tags wrong, want 101 and 203");
    end
    s_ready = 1'b0;
  endtask

  task automatic test_checksum();
    int nd, fb;
    pc = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd1;
    for (int i = 0; i < 256; i++) mems[i] = 32'd2;
    build_expected(NREG, NMEM);
    collect(2, -1);
    tests++;
    if (got_q.size() != 65 + CSUM) begin
      fails++; $display("FAIL csum_count: beats=%0d want %0d", got_q.size(), 65 + CSUM);
    end
    nd = stream_diffs(fb);
    tests++;
    if (nd != 0) begin
      fails++; $display("FAIL csum_stream: %0d bad beats, first at %0d", nd, fb);
    end
`ifdef DUMP_CHECKSUM_EN
    tests++;
    if (got_q.size() < 66 || got_q[65] !== {10'h300, 32'd96}) begin
      fails++; $display("FAIL csum_value: last beat wrong, want tag 300 data 96");
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 256; i++) mems[i] = '0;
    test_reset();
    test_basic();
    test_backpressure(1);
    test_backpressure(2);
    test_restart_ignored();
    test_reset_mid_dump();
    test_small_config();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Hardware readout engine for the single-cycle CPU: on request, halts the core and streams its architectural state out over a valid/ready port.
- Stream order: PC, then R0..R31, then data memory words 0..MEM_WORDS-1.
- Sits beside Simple_Single_CPU. Uses a spare read port on the register file and on data memory, plus a PC tap.
- Lets a host or board-level logic pull the state dump without hierarchical probing.

Parameters:
- MEM_WORDS, 32, number of 32-bit data-memory words dumped (1..256).
- REG_COUNT, 32, number of registers dumped (1..32).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  dump request, sampled only in IDLE.
- pc_i  in  32  current PC value.
- reg_addr_o  out  5  register-file read address.
- reg_data_i  in  32  register-file read data, combinational from reg_addr_o.
- mem_addr_o  out  32  data-memory byte address, word aligned.
- mem_data_i  in  32  data-memory read data, combinational from mem_addr_o.
- halt_o  out  1  freezes the CPU PC/writes while high.
- busy_o  out  1  dump in progress.
- dout_o  out  32  stream data.
- dout_tag_o  out  10  {kind[1:0], index[7:0]}; kind 0=PC, 1=REG, 2=MEM, 3=CSUM.
- dout_valid_o  out  1  stream valid.
- dout_ready_i  in  1  stream ready.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, immediate): state IDLE, index 0. All outputs 0: halt_o, busy_o, dout_valid_o, done_o, dout_o, dout_tag_o, reg_addr_o, mem_addr_o.
- FSM states: IDLE, S_PC, S_REG, S_MEM, (S_CSUM), S_FIN.
  - IDLE -> S_PC on the edge where start_i=1. busy_o and halt_o go 1 at that edge and stay 1 until S_FIN exits.
  - Load condition: in S_PC/S_REG/S_MEM/S_CSUM, the output register loads on an edge where dout_valid_o==0 or dout_ready_i==1. At a load, dout_o/dout_tag_o take the current word and dout_valid_o=1, then the state/index advance.
  - If the load condition holds but no more words remain (S_FIN), dout_valid_o clears.
  - S_PC loads pc_i, tag {0,0}, then moves to S_REG with index 0.
  - S_REG: reg_addr_o = index[4:0]. Loads reg_data_i with tag {1,index}. After index REG_COUNT-1 moves to S_MEM with index 0.
  - S_MEM: mem_addr_o = index*4. Loads mem_data_i with tag {2,index}. After MEM_WORDS-1 moves to S_FIN (or S_CSUM).
  - S_FIN: waits until the final beat is accepted (valid & ready). On the next edge: done_o=1 for one cycle; busy_o, halt_o, valid -> 0; IDLE.
- Latency: start_i edge t -> first valid after edge t+1. With ready held high: one beat per cycle, 1+REG_COUNT+MEM_WORDS beats (65 default), done_o pulses 1 cycle after the last handshake.
- Backpressure: while valid && !ready, dout_o and dout_tag_o hold stable and no address advances. Read addresses stay pointing at the next word to load.
- reg_addr_o and mem_addr_o are driven only in their own state, 0 otherwise.
- start_i while busy is ignored. start_i held high re-triggers only after returning to IDLE, at least 1 idle cycle between dumps.
- rst_i mid-dump: stream aborts immediately, no done_o. halt_o drops, releasing the CPU.
- Index is 8-bit and never wraps beyond its state limit.

Optional Feature:
- DUMP_CHECKSUM_EN defined:
  - A 32-bit running sum (modulo 2^32) accumulates every emitted data word, cleared on start.
  - After the last MEM word, S_CSUM emits the sum with tag {3,0}, for 2+REG_COUNT+MEM_WORDS beats.
- Not defined: no S_CSUM state and no accumulator. Kind 3 is never produced.

Test Plan:
- Reset, pc_i=0x40, R[i]=i*3, mem[i]=100+i, ready=1, start pulse:
  - 65 beats: PC 0x40 tag 0x000.
  - R5=15 tag 0x105.
  - mem[31]=131 tag 0x21F.
  - done_o exactly one cycle after beat 65; halt_o high from start edge through done.
- Same setup, ready toggling 1,0,0,1 repeatedly: every word delivered once in order, values stable while stalled, no duplicates or skips.
- start_i pulsed again at beat 10: ignored, a single 65-beat dump.
- rst_i asserted at beat 20 mid-stall: valid/halt/busy go 0 immediately without a clock edge. A fresh start then restarts from PC.
- MEM_WORDS=4, REG_COUNT=2: 7 beats, tags 0x000, 0x100, 0x101, 0x200..0x203.
- DUMP_CHECKSUM_EN, all registers 1, all memory 2, pc_i=0: beat 66 = 96 (32*1 + 32*2) with tag 0x300. Without the macro, 65 beats.
